// File: rtl/brq_dmem_bridge.sv
// Core LDST to single-outstanding word bus bridge: byte-lane steering, load extension, WAIT timeout.
// Optional BRQ_DMEM_MISALIGN_EN: misaligned H/W accesses raise dmem_err instead of being aligned down.
module brq_dmem_bridge #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 15,
    parameter int TimeoutCycles = 255
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [AddrWidth-1:0] core_addr,
    input  logic [DataWidth-1:0] core_wdata,
    input  logic                 core_ren,
    input  logic                 core_wen,
    input  logic [2:0]           core_size,
    output logic [DataWidth-1:0] core_rdata,
    output logic                 core_stall,
    output logic                 dmem_err,
    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic                 bus_we,
    output logic [AddrWidth-3:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [DataWidth-1:0] bus_wdata,
    input  logic                 bus_rsp_valid,
    input  logic [DataWidth-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] CLS_B = 2'd0;
    localparam logic [1:0] CLS_H = 2'd1;
    localparam logic [1:0] CLS_W = 2'd2;

    // Last WAIT cycle index; the abort happens on this cycle if no response arrives.
    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

    // Access class from func3: undefined encodings (011, 11x) fall into W.
    function automatic logic [1:0] size_class(input logic [2:0] size);
        logic [1:0] cls;
        case (size[1:0])
            2'b00:   cls = CLS_B;
            2'b01:   cls = CLS_H;
            default: cls = CLS_W;
        endcase
        return cls;
    endfunction

    // H uses only addr[1] and W ignores the offset, which aligns misaligned accesses down.
    function automatic logic [3:0] byte_enable(input logic [1:0] cls, input logic [1:0] off);
        logic [3:0] be;
        case (cls)
            CLS_B:   be = 4'b0001 << off;
            CLS_H:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] cls, input logic [31:0] data);
        logic [31:0] rep;
        case (cls)
            CLS_B:   rep = {4{data[7:0]}};
            CLS_H:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] cls, input logic uns,
                                                 input logic [1:0] off, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (cls)
            CLS_B:   res = {{24{b[7] & ~uns}}, b};
            CLS_H:   res = {{16{h[15] & ~uns}}, h};
            default: res = data;
        endcase
        return res;
    endfunction

`ifdef BRQ_DMEM_MISALIGN_EN
    function automatic logic misaligned(input logic [1:0] cls, input logic [1:0] off);
        return ((cls == CLS_H) && off[0]) || ((cls == CLS_W) && (off != 2'b00));
    endfunction
`endif

    state_t      state;
    state_t      state_nxt;
    logic        start;
    logic        mis;
    logic        timeout;
    logic [7:0]  wait_cnt;
    logic [1:0]  off_q;
    logic [1:0]  cls_q;
    logic        uns_q;
    logic [1:0]  cls_in;

    assign start   = core_ren | core_wen;
    assign cls_in  = size_class(core_size);
    assign timeout = (wait_cnt == TimeoutLast);

`ifdef BRQ_DMEM_MISALIGN_EN
    assign mis = misaligned(cls_in, core_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    // State register
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !mis) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    state_nxt = bus_we ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rsp_valid || timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; stall in IDLE follows the strobe so the core holds this cycle.
    always_comb begin
        core_stall    = 1'b1;
        bus_req_valid = 1'b0;
        case (state)
            S_IDLE:  core_stall = start;
            S_REQ:   bus_req_valid = 1'b1;
            default: core_stall = 1'b1;
        endcase
    end

    // Request capture, response extraction and WAIT timeout
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            core_rdata <= '0;
            dmem_err   <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            wait_cnt   <= '0;
            off_q      <= '0;
            cls_q      <= CLS_B;
            uns_q      <= 1'b0;
        end else begin
            dmem_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && mis) begin
                        dmem_err   <= 1'b1;
                        core_rdata <= '0;
                    end else if (start) begin
                        bus_we    <= core_wen;
                        bus_addr  <= core_addr[AddrWidth-1:2];
                        bus_be    <= byte_enable(cls_in, core_addr[1:0]);
                        bus_wdata <= lane_replicate(cls_in, core_wdata);
                        off_q     <= core_addr[1:0];
                        cls_q     <= cls_in;
                        uns_q     <= core_size[2];
                    end
                end
                S_REQ: begin
                    if (bus_req_ready && !bus_we) begin
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus_rsp_valid) begin
                        core_rdata <= load_extract(cls_q, uns_q, off_q, bus_rdata);
                    end else if (timeout) begin
                        core_rdata <= '0;
                        dmem_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_brq_dmem_bridge.sv
// Directed and randomized bench for brq_dmem_bridge against a byte-lane arithmetic reference model.
module tb_brq_dmem_bridge;

    localparam int TMO = 255;

    logic        brq_clk = 1'b0;
    logic        brq_rst;
    logic [14:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ren;
    logic        core_wen;
    logic [2:0]  core_size;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        dmem_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [12:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata;

    brq_dmem_bridge #(
        .DataWidth(32),
        .AddrWidth(15),
        .TimeoutCycles(TMO)
    ) dut (
        .brq_clk(brq_clk),
        .brq_rst(brq_rst),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_ren(core_ren),
        .core_wen(core_wen),
        .core_size(core_size),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .dmem_err(dmem_err),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata(bus_rdata)
    );

    always #5 brq_clk = ~brq_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Lowest byte lane of the access once aligned down to its natural size.
    function automatic int lane(input int addr, input int n);
        return ((addr % 4) / n) * n;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] size, input int addr);
        int n;
        n = nbytes(size);
        return 32'(((1 << n) - 1) << lane(addr, n));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] wd);
        int n;
        n = nbytes(size);
        if (n == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] size, input int addr, input logic [31:0] rd);
        int          n;
        logic [31:0] mask;
        logic [31:0] v;
        n = nbytes(size);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rd >> (8 * lane(addr, n))) & mask;
        if (!size[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_mis(input logic [2:0] size, input int addr);
`ifdef BRQ_DMEM_MISALIGN_EN
        return (addr % nbytes(size)) != 0;
`else
        return (size === 3'bxxx) && (addr < 0);
`endif
    endfunction

    // One core access; rdy = REQ cycles before ready, rsp = WAIT cycles before response (-1: none).
    task automatic txn(input string tag, input bit we, input logic [2:0] size, input int addr,
                       input logic [31:0] wd, input int rdy, input int rsp, input logic [31:0] rd);
        int          stalls;
        int          valids;
        int          req_cnt;
        int          wait_cnt;
        int          exp_stalls;
        bit          accepted;
        bit          was_acc;
        bit          done;
        bit          err_seen;
        bit          mis;
        bit          tmo;
        logic [31:0] rdata_done;
        stalls = 0; valids = 0; req_cnt = 0; wait_cnt = 0;
        accepted = 0; done = 0; err_seen = 0; rdata_done = '0;
        mis = m_mis(size, addr);
        tmo = !we && !mis && (rsp < 0);
        @(negedge brq_clk);
        core_addr  = 15'(addr);
        core_size  = size;
        core_wdata = wd;
        core_wen   = we;
        core_ren   = !we;
        bus_rdata  = rd;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge brq_clk);
                core_ren = 1'b0;
                core_wen = 1'b0;
            end
            bus_req_ready = bus_req_valid && (req_cnt >= rdy);
            bus_rsp_valid = accepted && (rsp >= 0) && (wait_cnt == rsp);
            #1;
            if (dmem_err) err_seen = 1;
            if (!core_stall) begin
                done = 1;
                rdata_done = core_rdata;
            end else begin
                stalls++;
            end
            was_acc = accepted;
            if (bus_req_valid) begin
                valids++;
                req_cnt++;
                check({tag, " bus_we"}, 32'(bus_we), 32'(we));
                check({tag, " bus_addr"}, 32'(bus_addr), 32'(addr / 4));
                check({tag, " bus_be"}, 32'(bus_be), m_be(size, addr));
                check({tag, " bus_wdata"}, bus_wdata, m_wdata(size, wd));
                if (bus_req_ready) accepted = 1;
            end
            if (was_acc) wait_cnt++;
        end
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        check({tag, " completed"}, 32'(done), 32'd1);
        if (mis) exp_stalls = 1;
        else exp_stalls = 1 + (rdy + 1) + (we ? 0 : (tmo ? TMO : rsp + 1));
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, " req_cycles"}, 32'(valids), mis ? 32'd0 : 32'(rdy + 1));
        check({tag, " dmem_err"}, 32'(err_seen), 32'(mis || tmo));
        if (mis || tmo) model_rdata = '0;
        else if (!we) model_rdata = m_load(size, addr, rd);
        check({tag, " core_rdata"}, rdata_done, model_rdata);
        @(negedge brq_clk);
        #1;
        check({tag, " err_pulse_end"}, 32'(dmem_err), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " core_rdata"}, core_rdata, 32'd0);
        check({tag, " dmem_err"}, 32'(dmem_err), 32'd0);
        check({tag, " core_stall"}, 32'(core_stall), 32'd0);
        check({tag, " bus_req_valid"}, 32'(bus_req_valid), 32'd0);
        check({tag, " bus_we"}, 32'(bus_we), 32'd0);
        check({tag, " bus_be"}, 32'(bus_be), 32'd0);
        check({tag, " bus_addr"}, 32'(bus_addr), 32'd0);
        check({tag, " bus_wdata"}, bus_wdata, 32'd0);
    endtask

    initial begin
        brq_rst       = 1'b0;
        core_addr     = '0;
        core_wdata    = '0;
        core_ren      = 1'b0;
        core_wen      = 1'b0;
        core_size     = '0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = '0;
        model_rdata   = '0;

        repeat (3) @(negedge brq_clk);
        #1;
        check_all_zero("reset");
        @(negedge brq_clk);
        brq_rst = 1'b1;

        txn("st_w", 1'b1, 3'b010, 32'h0010, 32'hCAFE_BABE, 0, -1, 32'h0);
        txn("ld_b", 1'b0, 3'b000, 32'h0013, 32'h0, 0, 0, 32'h80FF_FF7F);
        check("ld_b value", model_rdata, 32'hFFFF_FF80);
        txn("ld_bu", 1'b0, 3'b100, 32'h0013, 32'h0, 0, 0, 32'h80FF_FF7F);
        check("ld_bu value", model_rdata, 32'h0000_0080);
        txn("st_h_wait", 1'b1, 3'b001, 32'h0002, 32'h0000_1234, 3, -1, 32'h0);
        txn("ld_w_tmo", 1'b0, 3'b010, 32'h0040, 32'h0, 0, -1, 32'h5555_AAAA);
        txn("ld_h_mis", 1'b0, 3'b001, 32'h0001, 32'h0, 0, 1, 32'h1234_8765);
        txn("ld_w_mis", 1'b0, 3'b010, 32'h0107, 32'h0, 1, 2, 32'hA5A5_0F0F);
        txn("ld_undef", 1'b0, 3'b111, 32'h0200, 32'h0, 2, 3, 32'h0BAD_F00D);
        txn("ld_hu", 1'b0, 3'b101, 32'h0006, 32'h0, 0, 0, 32'h9876_5432);

        for (int i = 0; i < 30; i++) begin
            txn("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                int'($urandom_range(0, 32767)), $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), $urandom);
        end

        txn("ld_pre", 1'b0, 3'b010, 32'h0030, 32'h0, 0, 0, 32'h1111_2222);
        @(negedge brq_clk);
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'h1357_2468;
        repeat (2) @(negedge brq_clk);
        #1;
        check("idle_rsp core_rdata", core_rdata, model_rdata);
        check("idle_rsp core_stall", 32'(core_stall), 32'd0);
        check("idle_rsp bus_req_valid", 32'(bus_req_valid), 32'd0);
        bus_rsp_valid = 1'b0;

        @(negedge brq_clk);
        core_addr     = 15'h0020;
        core_size     = 3'b010;
        core_ren      = 1'b1;
        bus_req_ready = 1'b1;
        @(negedge brq_clk);
        core_ren = 1'b0;
        @(negedge brq_clk);
        bus_req_ready = 1'b0;
        #1;
        check("mid_wait core_stall", 32'(core_stall), 32'd1);
        check("mid_wait bus_req_valid", 32'(bus_req_valid), 32'd0);
        #1;
        brq_rst = 1'b0;
        #1;
        check_all_zero("rst_in_wait");
        @(negedge brq_clk);
        brq_rst       = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge brq_clk);
            #1;
            check("late_rsp bus_req_valid", 32'(bus_req_valid), 32'd0);
            check("late_rsp core_stall", 32'(core_stall), 32'd0);
            check("late_rsp core_rdata", core_rdata, 32'd0);
        end
        bus_rsp_valid = 1'b0;
        model_rdata   = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/brq_dmem_bridge.md
BRQ_DMEM_BRIDGE -- requirements
Module: brq_dmem_bridge

Interface
REQ-001 Parameter DataWidth, default 32, data path width; fixed at 32.
REQ-002 Parameter AddrWidth, default 15, core-side byte address width.
REQ-003 Parameter TimeoutCycles, default 255, maximum WAIT cycles before abort; range 1..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: brq_clk input 1 is the sole clock, all state rising-edge; brq_rst input 1 is the reset, async assert, active low.
REQ-005 core_addr  in  AddrWidth  byte address from core LDST stage.
REQ-006 core_wdata  in  32  store data, right-justified.
REQ-007 core_ren / core_wen  in  1 each  load / store request strobe.
REQ-008 core_size  in  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 core_rdata  out  32  aligned, extended load result.
REQ-010 core_stall  out  1  hold core pipeline.
REQ-011 dmem_err  out  1  one-cycle error pulse.
REQ-012 bus_req_valid  out  1; bus_req_ready  in  1.
REQ-013 bus_we  out  1; bus_addr  out  AddrWidth-2  word address; bus_be  out  4; bus_wdata  out  32.
REQ-014 bus_rsp_valid  in  1; bus_rdata  in  32.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT.
- IDLE: on core_ren|core_wen, latch addr/size/wdata/direction and go to REQ.
- core_wen wins when both strobes are high.
REQ-016 core_stall SHALL be combinationally high in IDLE when a strobe is present, and high throughout REQ and WAIT.
REQ-017 REQ SHALL hold bus_req_valid=1 with all bus_* fields stable until bus_req_ready=1.
- Store: go to IDLE.
- Load: go to WAIT.
REQ-018 WAIT SHALL capture bus_rdata on bus_rsp_valid=1, register the result into core_rdata and go to IDLE; core_stall drops in that same IDLE cycle.
REQ-019 bus_be SHALL be: B = 0001<<addr[1:0]; H = 0011<<{addr[1],0}; W = 1111.
- bus_wdata replicates the byte or halfword across all lanes.
REQ-020 Load alignment SHALL select the addressed byte or halfword.
- B and H sign-extend; BU and HU zero-extend; W passes through.
REQ-021 An 8-bit WAIT counter SHALL reset on entry to WAIT.
- On reaching TimeoutCycles without bus_rsp_valid: core_rdata = 0, dmem_err pulses, FSM returns to IDLE.
REQ-022 bus_rsp_valid outside WAIT SHALL be ignored.
REQ-023 Latency: a store with ready already high stalls 2 cycles; a load with zero-wait response stalls 3 cycles.
REQ-024 An undefined core_size (011, 11x) SHALL be treated as W.

Reset
REQ-025 While brq_rst=0, the block SHALL be held as follows:
- FSM in IDLE; counter 0.
- core_rdata = 0; dmem_err = 0; core_stall = 0.
- bus_req_valid = 0; bus_we = 0; bus_be = 0; bus_addr = 0; bus_wdata = 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction immediately with no bus retry after release.

Configuration
REQ-027 Macro BRQ_DMEM_MISALIGN_EN defined:
- H with addr[0]=1, or W with addr[1:0]!=0, issues no bus request.
- dmem_err pulses, core_stall is high 1 cycle, core_rdata = 0.
REQ-028 Macro undefined: misaligned addresses SHALL be silently aligned down (H clears bit 0, W clears bits 1:0) and complete normally; dmem_err only on timeout.

Verification
REQ-029 Store W 0xCAFEBABE to 0x0010, ready=1 -> bus_addr=0x004, bus_be=1111, bus_we=1; stall high exactly 2 cycles.
REQ-030 Load B from 0x0013, bus_rdata=0x80FF_FF7F -> core_rdata=0xFFFFFF80; same with BU -> 0x00000080.
REQ-031 Store H 0x1234 to 0x0002, ready low 3 cycles -> bus_be=1100, bus_wdata=0x12341234 stable; valid held 4 cycles.
REQ-032 Load W, no bus_rsp_valid for 255 cycles -> dmem_err pulse, core_rdata=0, FSM in IDLE.
REQ-033 Load H at 0x0001 -> macro on: no bus_req_valid, dmem_err=1; macro off: bus_be=0011.
REQ-034 brq_rst low while in WAIT -> all outputs 0 next edge; a late bus_rsp_valid is ignored.
